bloom_pattern_loader: RTL and testbench
=======================================

Name: bloom_pattern_loader

Overview:
- Write side of the Bloom pattern search. Patterns arrive byte-serially over a valid/ready stream.
- The block computes, one byte per cycle, the same CRC32 (poly 0x82608EDB) that the search datapath computes combinationally.
- It then sets the matching bit in the Bloom bit-array RAM by read-modify-write.
- It also provides a full-array clear sweep so the array can be re-programmed.

Parameters:
- BYTES_CNT, 15: exact pattern length in bytes; must equal the search-side hash width.
- HASH_W, 12: Bloom index width; the array holds 2^HASH_W bits.
- MEM_DW, 32: RAM word width, power of two, ≤ 2^HASH_W.
- Derived: BIT_W = log2(MEM_DW); ADDR_W = HASH_W - BIT_W.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active-low
- byte_i  in  8  pattern byte
- byte_valid_i  in  1  byte_i valid
- byte_last_i  in  1  final byte of pattern
- byte_ready_o  out  1  byte accepted when valid&&ready
- clear_i  in  1  pulse: zero the whole array
- mem_rd_en_o  out  1  RAM read strobe
- mem_rd_addr_o  out  ADDR_W  read address
- mem_rd_data_i  in  MEM_DW  read data, valid 1 cycle after mem_rd_en_o
- mem_wr_en_o  out  1  RAM write strobe
- mem_wr_addr_o  out  ADDR_W  write address
- mem_wr_data_o  out  MEM_DW  write data
- hash_o  out  HASH_W  index of last programmed pattern
- done_o  out  1  1-cycle pulse: pattern bit written
- err_len_o  out  1  1-cycle pulse: pattern length ≠ BYTES_CNT, discarded
- busy_o  out  1  high in any state other than IDLE/ACC

Behaviour:
- Reset (rst_n_i low at a clock edge): state IDLE, CRC = 32'hFFFFFFFF, byte count 0.
  - All strobes and pulses 0, hash_o 0, byte_ready_o 0.
  - Reset mid-RMW or mid-clear aborts at once; a partially cleared array is acceptable.
- CRC rules:
  - Init all-ones; no reflection; no final XOR.
  - Stream byte k is string byte k, processed first-to-last. The result must be bit-identical to the search-side hash of the same BYTES_CNT bytes.
  - hash = crc[HASH_W-1:0]; word address = hash[HASH_W-1:BIT_W]; bit select = hash[BIT_W-1:0].
- State machine:
  - IDLE: byte_ready_o=1.
    - clear_i → CLR. clear_i has priority over a simultaneous valid byte; that byte is not accepted.
    - An accepted byte → ACC (CRC updated, count=1).
  - ACC: byte_ready_o=1; each accepted byte updates the CRC and increments the count (saturates at BYTES_CNT+1). clear_i is ignored in ACC.
    - On an accepted byte with byte_last_i, if final count == BYTES_CNT → RD and latch hash_o.
    - On an accepted byte with byte_last_i, if final count ≠ BYTES_CNT → ERR.
  - ERR: err_len_o=1 for one cycle; CRC/count reinit; → IDLE. No RAM access.
  - RD: mem_rd_en_o=1 at the word address; → WT.
  - WT: capture mem_rd_data_i; → WR.
  - WR: mem_wr_en_o=1, same address, data = rd_data | (1<<bit); done_o=1; CRC/count reinit; → IDLE.
  - CLR: writes zero to addresses 0..2^ADDR_W-1, one per cycle; → IDLE after the last address, then pulses done_o once.
- byte_ready_o is 0 in RD, WT, WR, ERR, CLR. Minimum per-pattern cost is BYTES_CNT + 3 cycles.
- Single-byte pattern (BYTES_CNT > 1) with last in IDLE → ERR path.
- If BYTES_CNT = 1, last on the first byte → RD.
- Read and write to the same address never overlap; the RAM needs no bypass.
- mem_* addresses are 0 whenever their strobe is low.

Decomposition:
- Package bloom_pkg holds:
  - POLY constant 32'h82608EDB and CRC_INIT 32'hFFFFFFFF.
  - The byte-step function crc32_step(d[7:0], c[31:0]), shared so the search-side module and this block cannot diverge.
  - The loader state enum.
- One sub-module, crc32_serial: registered CRC with init/en/byte inputs, 1-cycle update.

Test Plan:
- "ABCDEFGHIJKLMNO" (15 bytes, last on 'O') → one read at addr = hash[11:5], then a write setting bit hash[4:0]. hash_o equals the combinational search-side hash of the same string; done_o pulses once.
- The same pattern twice with the RAM model → second write data equals first (bit already set); the array is unchanged.
- 14-byte and 16-byte patterns → err_len_o pulse, no mem_rd_en_o/mem_wr_en_o. Next valid 15-byte pattern is hashed with fresh CRC init.
- Back-to-back valid patterns with byte_valid_i held high → byte_ready_o drops for exactly 3 cycles between them; both bits set.
- clear_i in IDLE with a byte valid in the same cycle → 128 zero writes to addresses 0..127, byte not accepted, done_o once.
  - Also: reset asserted during CLR at address 40 → writes stop the next cycle and all outputs return to 0.
- Pattern bytes all 8'h00 → hash_o matches the reference model (CRC of zeros from all-ones init, not 0).

Source files
------------

// File: rtl/bloom_pkg.sv
// Shared definitions for the Bloom pattern search: CRC32 byte step and loader states.
// Both the search datapath and the loader use crc32_step so their hashes cannot diverge.
package bloom_pkg;

    localparam logic [31:0] POLY     = 32'h82608EDB;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_ERR,
        ST_RD,
        ST_WT,
        ST_WR,
        ST_CLR
    } ld_state_e;

    // MSB-first, non-reflected: bit 7 of the byte enters first.
    function automatic logic [31:0] crc32_step(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

endpackage

// File: rtl/bloom_pattern_loader_crc.sv
// crc32_serial: registered CRC32, one byte per cycle.
// hash_nxt_o is the low HASH_W bits of the CRC including the byte on data_i.
module crc32_serial
    import bloom_pkg::*;
#(
    parameter int HASH_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_i,
    input  logic              en_i,
    input  logic [7:0]        data_i,
    output logic [HASH_W-1:0] hash_nxt_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc32_step(data_i, crc_q);
        crc_d   = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc_nxt;
        end
    end

    assign hash_nxt_o = crc_nxt[HASH_W-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/bloom_pattern_loader.sv
// Write side of the Bloom pattern search: hashes byte-serial patterns and
// sets the matching bit in the Bloom array by read-modify-write; also clears it.
module bloom_pattern_loader
    import bloom_pkg::*;
#(
    parameter  int BYTES_CNT = 15,
    parameter  int HASH_W    = 12,
    parameter  int MEM_DW    = 32,
    localparam int BIT_W     = $clog2(MEM_DW),
    localparam int ADDR_W    = HASH_W - BIT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    input  logic              clear_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [MEM_DW-1:0] mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [MEM_DW-1:0] mem_wr_data_o,
    output logic [HASH_W-1:0] hash_o,
    output logic              done_o,
    output logic              err_len_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BYTES_CNT + 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BYTES_CNT);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(BYTES_CNT + 1);
    localparam logic [MEM_DW-1:0] BIT_ONE  = MEM_DW'(1);

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic [MEM_DW-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_done_q, clr_done_d;

    logic              crc_init;
    logic              crc_en;
    logic [HASH_W-1:0] hash_nxt;
    logic [CNT_W-1:0]  cnt_new;
    logic              ready;
    logic [ADDR_W-1:0] word_addr;
    logic [BIT_W-1:0]  bit_sel;

    crc32_serial #(
        .HASH_W (HASH_W)
    ) u_crc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .init_i     (crc_init),
        .en_i       (crc_en),
        .data_i     (byte_i),
        .hash_nxt_o (hash_nxt)
    );

    assign word_addr = hash_q[HASH_W-1:BIT_W];
    assign bit_sel   = hash_q[BIT_W-1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hash_d        = hash_q;
        rdata_d       = rdata_q;
        clr_addr_d    = clr_addr_q;
        clr_done_d    = 1'b0;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        ready         = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        done_o        = clr_done_q;
        err_len_o     = 1'b0;

        if (state_q == ST_IDLE) begin
            cnt_new = CNT_ONE;
        end else if (cnt_q == CNT_SAT) begin
            cnt_new = cnt_q;
        end else begin
            cnt_new = cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_ACC: begin
                // A clear request wins over a byte offered in the same cycle.
                ready = !(state_q == ST_IDLE && clear_i);
                if (state_q == ST_IDLE && clear_i) begin
                    state_d    = ST_CLR;
                    clr_addr_d = '0;
                end else if (byte_valid_i) begin
                    crc_en  = 1'b1;
                    cnt_d   = cnt_new;
                    state_d = ST_ACC;
                    if (byte_last_i) begin
                        if (cnt_new == CNT_FULL) begin
                            state_d = ST_RD;
                            hash_d  = hash_nxt;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
            end
            ST_ERR: begin
                err_len_o = 1'b1;
                crc_init  = 1'b1;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
            ST_RD: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = word_addr;
                state_d       = ST_WT;
            end
            ST_WT: begin
                rdata_d = mem_rd_data_i;
                state_d = ST_WR;
            end
            ST_WR: begin
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = word_addr;
                mem_wr_data_o = rdata_q | (BIT_ONE << bit_sel);
                done_o        = 1'b1;
                crc_init      = 1'b1;
                cnt_d         = '0;
                state_d       = ST_IDLE;
            end
            ST_CLR: begin
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = clr_addr_q;
                if (clr_addr_q == '1) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_ready_o = ready && rst_n_i;
    assign hash_o       = hash_q;
    assign busy_o       = !(state_q == ST_IDLE || state_q == ST_ACC);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hash_q     <= '0;
            rdata_q    <= '0;
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hash_q     <= hash_d;
            rdata_q    <= rdata_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_bloom_pattern_loader.sv
// Scoreboard bench for bloom_pattern_loader with a 128x32 RAM model.
// Stimulus pushes expected RAM/pulse events; a negedge monitor pops and compares.
module tb_bloom_pattern_loader;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [11:0] hash;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        byte_ready_o;
    logic        clear_i;
    logic        mem_rd_en_o;
    logic [6:0]  mem_rd_addr_o;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en_o;
    logic [6:0]  mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;
    logic [11:0] hash_o;
    logic        done_o;
    logic        err_len_o;
    logic        busy_o;

    int          n_chk = 0;
    int          n_err = 0;
    ev_t         exp_q[$];
    logic [7:0]  pat[0:31];
    logic [31:0] mem[0:127];
    logic [31:0] exp_mem[0:127];
    logic        load_mem;
    logic [11:0] cur_hash;

    always #5 clk = ~clk;

    bloom_pattern_loader dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .byte_last_i   (byte_last_i),
        .byte_ready_o  (byte_ready_o),
        .clear_i       (clear_i),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wr_addr_o (mem_wr_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .hash_o        (hash_o),
        .done_o        (done_o),
        .err_len_o     (err_len_o),
        .busy_o        (busy_o)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'h0101_0101 * i) ^ 32'h00F0_0F00;
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en_o) begin
            mem[mem_wr_addr_o] <= mem_wr_data_o;
        end
        if (mem_rd_en_o) mem_rd_data <= mem[mem_rd_addr_o];
    end

    // Byte-at-a-time reference: XOR the byte into the top, then shift 8 times.
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {pat[k], 24'h0};
            for (int b = 0; b < 8; b++) begin
                if (c[31]) c = {c[30:0], 1'b0} ^ 32'h82608EDB;
                else       c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic push(input int k, input logic [6:0] a,
                        input logic [31:0] d, input logic [11:0] h);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.hash = h;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_pat(input int n);
        logic [31:0] c;
        logic [11:0] h;
        logic [6:0]  a;
        logic [31:0] d;
        if (n == 15) begin
            c = ref_crc(n);
            h = c[11:0];
            a = h[11:5];
            d = exp_mem[a] | (32'h1 << h[4:0]);
            push(K_RD, a, 32'h0, 12'h0);
            push(K_WR, a, d, 12'h0);
            push(K_DONE, 7'h0, 32'h0, h);
            exp_mem[a] = d;
            cur_hash = h;
        end else begin
            push(K_ERR, 7'h0, 32'h0, 12'h0);
        end
    endtask

    task automatic check_ev(input int k, input logic [6:0] a,
                            input logic [31:0] d, input logic [11:0] h);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none",
                     k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k ||
                ((k == K_RD || k == K_WR) && e.addr != a) ||
                (k == K_WR && e.data != d) ||
                (k == K_DONE && e.hash != h)) begin
                n_err++;
                $display("FAIL event: got kind %0d addr %h data %h hash %h, expected kind %0d addr %h data %h hash %h",
                         k, a, d, h, e.kind, e.addr, e.data, e.hash);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem_rd_en_o) check_ev(K_RD, mem_rd_addr_o, 32'h0, 12'h0);
        if (mem_wr_en_o) check_ev(K_WR, mem_wr_addr_o, mem_wr_data_o, 12'h0);
        if (done_o) check_ev(K_DONE, 7'h0, 32'h0, hash_o);
        if (err_len_o) check_ev(K_ERR, 7'h0, 32'h0, 12'h0);
        if (!mem_rd_en_o && mem_rd_addr_o != 7'h0) chk("rd_addr_idle", {25'h0, mem_rd_addr_o}, 32'h0);
        if (!mem_wr_en_o && mem_wr_addr_o != 7'h0) chk("wr_addr_idle", {25'h0, mem_wr_addr_o}, 32'h0);
    end

    task automatic load_str(input string s);
        for (int k = 0; k < s.len(); k++) pat[k] = s[k];
    endtask

    // Called at a negedge; leaves byte_valid_i high after the last byte.
    task automatic send(input int n, output int stall0);
        int t;
        stall0 = 0;
        for (int k = 0; k < n; k++) begin
            byte_i       = pat[k];
            byte_last_i  = (k == n - 1);
            byte_valid_i = 1'b1;
            t = 0;
            #1;
            while (!byte_ready_o && t < 500) begin
                if (k == 0) stall0++;
                t++;
                @(negedge clk);
                #1;
            end
            if (t >= 500) begin
                chk("send_timeout", 32'(t), 32'd0);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_inputs();
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        clear_i      = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_ready"}, {31'h0, byte_ready_o}, 32'h0);
        chk({nm, "_rd_en"}, {31'h0, mem_rd_en_o}, 32'h0);
        chk({nm, "_wr_en"}, {31'h0, mem_wr_en_o}, 32'h0);
        chk({nm, "_wr_addr"}, {25'h0, mem_wr_addr_o}, 32'h0);
        chk({nm, "_done"}, {31'h0, done_o}, 32'h0);
        chk({nm, "_err"}, {31'h0, err_len_o}, 32'h0);
        chk({nm, "_busy"}, {31'h0, busy_o}, 32'h0);
        chk({nm, "_hash"}, {20'h0, hash_o}, 32'h0);
    endtask

    task automatic run_pat(input string s, input int n);
        int st;
        if (s.len() > 0) load_str(s);
        expect_pat(n);
        send(n, st);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int t;
        logic [6:0] a;
        logic ok;
        rst_n    = 1'b0;
        load_mem = 1'b1;
        byte_i   = 8'h0;
        cur_hash = 12'h0;
        idle_inputs();
        for (int i = 0; i < 128; i++) exp_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst_n    = 1'b1;
        load_mem = 1'b0;
        @(negedge clk);
        chk("ready_idle", {31'h0, byte_ready_o}, 32'h1);

        run_pat("ABCDEFGHIJKLMNO", 15);
        a = cur_hash[11:5];
        chk("abc_mem", mem[a], exp_mem[a]);
        run_pat("ABCDEFGHIJKLMNO", 15);
        chk("abc_repeat_mem", mem[a], exp_mem[a]);

        run_pat("ABCDEFGHIJKLMN", 14);
        run_pat("ABCDEFGHIJKLMNOP", 16);
        run_pat("Q", 1);
        run_pat("PQRSTUVWXYZabcd", 15);

        load_str("0123456789abcde");
        expect_pat(15);
        send(15, st);
        load_str("fghijklmnopqrst");
        expect_pat(15);
        send(15, st);
        chk("b2b_stall", 32'(st), 32'd3);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        drain();

        for (int k = 0; k < 15; k++) pat[k] = 8'h00;
        run_pat("", 15);
        chk("zero_hash", {20'h0, hash_o}, {20'h0, ref_crc(15) & 32'hFFF});

        clear_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_last_i  = 1'b1;
        byte_i       = 8'h5A;
        #1;
        chk("clr_ready", {31'h0, byte_ready_o}, 32'h0);
        for (int i = 0; i < 128; i++) begin
            push(K_WR, 7'(i), 32'h0, 12'h0);
            exp_mem[i] = 32'h0;
        end
        push(K_DONE, 7'h0, 32'h0, cur_hash);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("clr_busy", {31'h0, busy_o}, 32'h1);
        drain();
        ok = 1'b1;
        for (int i = 0; i < 128; i++) if (mem[i] !== 32'h0) ok = 1'b0;
        chk("clr_all_zero", {31'h0, ok}, 32'h1);

        run_pat("ABCDEFGHIJKLMNO", 15);
        run_pat("Hello, Bloom!!!", 15);

        clear_i = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            push(K_WR, 7'(i), 32'h0, 12'h0);
            exp_mem[i] = 32'h0;
        end
        @(negedge clk);
        clear_i = 1'b0;
        t = 0;
        while (!(mem_wr_en_o && mem_wr_addr_o == 7'd40) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("clr_reach40", {31'h0, t < 300}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("clr_abort");
        rst_n    = 1'b1;
        cur_hash = 12'h0;
        @(negedge clk);
        chk("clr_abort_q", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);

        run_pat("ABCDEFGHIJKLMNO", 15);

        ok = 1'b1;
        for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) ok = 1'b0;
        chk("final_array", {31'h0, ok}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
